// File: rtl/i2c_master_engine_pkg.sv
// i2c_master_engine_pkg: command codes, FSM state encoding and quarter indices for the I2C master engine
package i2c_master_engine_pkg;
    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_WRITE,
        S_READ,
        S_ACK_OUT,
        S_ACK_IN,
        S_DONE
    } state_t;

    function automatic state_t cmd_state(input logic [1:0] c);
        return c == CMD_START ? S_START : c == CMD_STOP ? S_STOP : c == CMD_WRITE ? S_WRITE : S_READ;
    endfunction
endpackage

// File: rtl/i2c_master_engine_if.sv
// i2c_master_engine_if: command handshake, result and open-drain pin signals of the I2C master engine
interface i2c_master_engine_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd;
    logic              cmd_nack;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              ack_rx;
    logic              done;
    logic              busy;
    logic              sda_in;
    logic              scl_in;
    logic              sda_oe;
    logic              scl_oe;

    modport master (
        output cmd_valid, cmd, cmd_nack, tx_data, sda_in, scl_in,
        input  cmd_ready, rx_data, ack_rx, done, busy, sda_oe, scl_oe
    );

    modport slave (
        input  cmd_valid, cmd, cmd_nack, tx_data, sda_in, scl_in,
        output cmd_ready, rx_data, ack_rx, done, busy, sda_oe, scl_oe
    );
endinterface

// File: rtl/i2c_master_engine_quarter_timer.sv
// i2c_quarter_timer: CLK_DIV-cycle quarter counter with quarter index; hold freezes timing while the slave stretches SCL
module i2c_quarter_timer
    import i2c_master_engine_pkg::*;
#(
    parameter int CLK_DIV = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] q
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en & ~hold & (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            q   <= Q0;
        end else if (!hold) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            q   <= tick ? q + 2'd1 : q;
        end
    end
endmodule

// File: rtl/i2c_master_engine.sv
// i2c_master_engine: byte-level I2C master (START/STOP/WRITE/READ, ACK/NACK, open-drain drive).
// Define I2C_CLK_STRETCH_EN to freeze quarter timing while a slave holds SCL low.
module i2c_master_engine
    import i2c_master_engine_pkg::*;
#(
    parameter int CLK_DIV = 32,
    parameter int DATA_W  = 8
) (
    input logic clk,
    input logic rst,
    i2c_master_engine_if.slave b
);
`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    state_t            state, nxt;
    logic [1:0]        q;
    logic              tick, hold, active, slot, accept, slot_end, sample;
    logic [DATA_W-1:0] sh, rx;
    logic [2:0]        bitcnt;
    logic              ack_r, nack_r, sda_hold, scl_hold, sda_c, scl_c;

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (active),
        .hold(hold),
        .tick(tick),
        .q   (q)
    );

    assign active   = state != S_IDLE && state != S_DONE;
    assign slot     = state inside {S_WRITE, S_READ, S_ACK_OUT, S_ACK_IN};
    assign accept   = b.cmd_valid & b.cmd_ready;
    assign slot_end = tick & (q == Q3);
    assign sample   = tick & (q == Q1);
    assign hold     = STRETCH & ~scl_c & ~b.scl_in;

    // Outside a command the lines keep whatever the last command left on the bus.
    assign sda_c = state == S_START ? q[1] :
                   state == S_STOP ? ~q[1] :
                   state == S_WRITE ? ~sh[DATA_W-1] :
                   state == S_ACK_OUT ? ~nack_r :
                   slot ? 1'b0 : sda_hold;
    assign scl_c = state == S_START ? (q == Q0 ? scl_hold : q == Q3) :
                   state == S_STOP ? (q == Q0 & scl_hold) :
                   slot ? (q == Q0 || q == Q3) : scl_hold;

    assign b.sda_oe    = sda_c;
    assign b.scl_oe    = scl_c;
    assign b.cmd_ready = ~active & ~rst;
    assign b.busy      = active;
    assign b.done      = state == S_DONE;
    assign b.rx_data   = rx;
    assign b.ack_rx    = ack_r;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE:    nxt = accept ? cmd_state(b.cmd) : S_IDLE;
            S_START, S_STOP:   nxt = slot_end ? S_DONE : state;
            S_WRITE:           nxt = slot_end && bitcnt == 3'(DATA_W - 1) ? S_ACK_IN : state;
            S_READ:            nxt = slot_end && bitcnt == 3'(DATA_W - 1) ? S_ACK_OUT : state;
            S_ACK_OUT, S_ACK_IN: nxt = slot_end ? S_DONE : state;
            default:           nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sh       <= '0;
            rx       <= '0;
            bitcnt   <= '0;
            ack_r    <= 1'b0;
            nack_r   <= 1'b0;
            sda_hold <= 1'b0;
            scl_hold <= 1'b0;
        end else begin
            state    <= nxt;
            sda_hold <= sda_c;
            scl_hold <= scl_c;
            if (accept) begin
                sh     <= b.tx_data;
                nack_r <= b.cmd_nack;
                bitcnt <= '0;
            end
            if (sample && state == S_READ) rx <= {rx[DATA_W-2:0], b.sda_in};
            if (sample && state == S_ACK_IN) ack_r <= ~b.sda_in;
            if (slot_end && (state == S_WRITE || state == S_READ)) bitcnt <= bitcnt + 3'd1;
            if (slot_end && state == S_WRITE) sh <= {sh[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_i2c_master_engine.sv
// tb_i2c_master_engine: randomized command stimulus against an open-drain slave model and an I2C bus-level monitor
module tb_i2c_master_engine;
    import i2c_master_engine_pkg::*;

    localparam int D  = 4;
    localparam int LS = 4 * D + 1;
    localparam int LB = 36 * D + 1;
    localparam int ST = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_engine_if #(.DATA_W(8)) b();
    i2c_master_engine #(.CLK_DIV(D), .DATA_W(8)) dut (.clk(clk), .rst(rst), .b(b));

    logic       s_pull = 1'b0, scl_prev = 1'b1, sda_prev = 1'b1, s_ack = 1'b0, st_arm = 1'b0, exp_ack = 1'b0;
    logic [1:0] s_mode = CMD_START;
    logic [7:0] s_byte = 8'h00;
    int         s_slot = 0, st_cnt = 0, nb = 0, n_start = 0, n_stop = 0, checks = 0, errors = 0;
    logic       bits [16];

    wire sda_bus   = ~b.sda_oe & ~s_pull;
    wire s_stretch = st_arm & (s_mode == CMD_WRITE) & (s_slot == 3) & ~scl_prev & (st_cnt <= ST);
    wire scl_bus   = ~b.scl_oe & ~s_stretch;
    assign b.sda_in = sda_bus;
    assign b.scl_in = scl_bus;

    // Slave answers only while SCL is low; the monitor decodes bits on SCL rises and START/STOP conditions.
    always @(negedge clk) begin
        if (b.cmd_valid && b.cmd_ready) begin
            s_mode <= b.cmd;
            s_slot <= 0;
            st_cnt <= 0;
            nb     <= 0;
        end else begin
            if (scl_bus && !scl_prev) s_slot <= s_slot + 1;
            if (scl_bus && !scl_prev && nb < 16) begin
                bits[nb] <= sda_bus;
                nb       <= nb + 1;
            end
            if (s_stretch && !b.scl_oe) st_cnt <= st_cnt + 1;
        end
        if (!scl_bus)
            s_pull <= s_mode == CMD_READ ? (s_slot < 8 && !s_byte[3'(7 - s_slot)]) :
                      (s_mode == CMD_WRITE && s_slot == 8 && s_ack);
        if (scl_bus && scl_prev && sda_prev && !sda_bus) n_start <= n_start + 1;
        if (scl_bus && scl_prev && !sda_prev && sda_bus) n_stop <= n_stop + 1;
        scl_prev <= scl_bus;
        sda_prev <= sda_bus;
    end

    function automatic logic [7:0] bus_byte();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = bits[i];
        return v;
    endfunction

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic n, output int lat);
        b.cmd       = c;
        b.tx_data   = d;
        b.cmd_nack  = n;
        b.cmd_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            b.cmd_valid = 1'b0;
            lat++;
        end while (!b.done && lat < 2000);
        checks++;
        if (b.done !== 1'b1) begin
            errors++;
            $display("FAIL timeout cmd=%0d: done=%b after %0d cycles", c, b.done, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", b.cmd_ready); end
        checks++;
        if ({b.busy, b.done, b.sda_oe, b.scl_oe} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0000", {b.busy, b.done, b.sda_oe, b.scl_oe});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (b.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", b.cmd_ready); end
        checks++;
        if ({b.rx_data, b.ack_rx} !== 9'b0) begin errors++; $display("FAIL reset_rx_ack: got %h want 0", {b.rx_data, b.ack_rx}); end
    endtask

    task automatic test_start();
        int lat, ns;
        ns = n_start;
        run_cmd(CMD_START, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== LS) begin errors++; $display("FAIL start_latency: got %0d want %0d", lat, LS); end
        checks++;
        if (n_start !== ns + 1) begin errors++; $display("FAIL start_condition: got %0d want %0d", n_start - ns, 1); end
        checks++;
        if ({b.scl_oe, b.sda_oe, scl_bus} !== 3'b110) begin
            errors++; $display("FAIL start_bus: got %b want 110", {b.scl_oe, b.sda_oe, scl_bus});
        end
    endtask

    task automatic test_write();
        int lat;
        logic [7:0] d;
        logic a;
        for (int i = 0; i < 8; i++) begin
            d = i == 0 ? 8'h90 : i == 1 ? 8'h01 : 8'($urandom);
            a = i == 0 ? 1'b1 : i == 1 ? 1'b0 : 1'($urandom);
            s_ack = a;
            run_cmd(CMD_WRITE, d, 1'b0, lat);
            exp_ack = a;
            checks++;
            if (lat !== LB) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, LB); end
            checks++;
            if (bus_byte() !== d) begin errors++; $display("FAIL write_bits: got %h want %h", bus_byte(), d); end
            checks++;
            if (bits[8] !== ~a) begin errors++; $display("FAIL write_ack_bit: got %b want %b", bits[8], ~a); end
            checks++;
            if (b.ack_rx !== a) begin errors++; $display("FAIL write_ack_rx: got %b want %b", b.ack_rx, a); end
            checks++;
            if ({b.cmd_ready, b.busy, b.scl_oe} !== 3'b101) begin
                errors++; $display("FAIL write_idle: got %b want 101", {b.cmd_ready, b.busy, b.scl_oe});
            end
        end
    endtask

    task automatic test_read();
        int lat;
        logic n;
        for (int i = 0; i < 8; i++) begin
            s_byte = i < 2 ? 8'hA5 : 8'($urandom);
            n = i == 0 ? 1'b0 : i == 1 ? 1'b1 : 1'($urandom);
            run_cmd(CMD_READ, 8'($urandom), n, lat);
            checks++;
            if (lat !== LB) begin errors++; $display("FAIL read_latency: got %0d want %0d", lat, LB); end
            checks++;
            if (b.rx_data !== s_byte) begin errors++; $display("FAIL read_data: got %h want %h", b.rx_data, s_byte); end
            checks++;
            if (bus_byte() !== s_byte) begin errors++; $display("FAIL read_bus: got %h want %h", bus_byte(), s_byte); end
            checks++;
            if (bits[8] !== n) begin errors++; $display("FAIL read_ack_out: got %b want %b", bits[8], n); end
            checks++;
            if (b.ack_rx !== exp_ack) begin errors++; $display("FAIL read_ack_rx_kept: got %b want %b", b.ack_rx, exp_ack); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bad, np, seen;
        np = n_stop;
        s_ack = 1'b1;
        b.cmd = CMD_WRITE;
        b.tx_data = 8'($urandom);
        b.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b.cmd = CMD_STOP;
        lat = 1;
        bad = 0;
        while (!b.done && lat < 2000) begin
            if (b.cmd_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        b.cmd_valid = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL busy_ready: got %0d ready cycles want 0", bad); end
        checks++;
        if (lat !== LB) begin errors++; $display("FAIL busy_latency: got %0d want %0d", lat, LB); end
        exp_ack = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (b.done || b.busy) seen++;
        end
        checks++;
        if (seen !== 0 || n_stop !== np) begin
            errors++; $display("FAIL busy_not_queued: got %0d active cycles %0d stops want 0 0", seen, n_stop - np);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [6] = '{CMD_START, CMD_WRITE, CMD_START, CMD_WRITE, CMD_READ, CMD_STOP};
        int lat, ns, np, want;
        ns = n_start;
        np = n_stop;
        for (int i = 0; i < 6; i++) begin
            s_ack  = 1'b1;
            s_byte = 8'($urandom);
            run_cmd(seq[i], 8'($urandom), i == 4, lat);
            want = (seq[i] == CMD_START || seq[i] == CMD_STOP) ? LS : LB;
            checks++;
            if (lat !== want) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, want); end
            checks++;
            if (b.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, b.cmd_ready); end
            if (seq[i] == CMD_READ) begin
                checks++;
                if (b.rx_data !== s_byte) begin errors++; $display("FAIL b2b_read: got %h want %h", b.rx_data, s_byte); end
            end
        end
        exp_ack = 1'b1;
        checks++;
        if (n_start - ns !== 2 || n_stop - np !== 1) begin
            errors++; $display("FAIL b2b_conditions: got %0d starts %0d stops want 2 1", n_start - ns, n_stop - np);
        end
        checks++;
        if ({b.sda_oe, b.scl_oe, sda_bus, scl_bus} !== 4'b0011) begin
            errors++; $display("FAIL b2b_released: got %b want 0011", {b.sda_oe, b.scl_oe, sda_bus, scl_bus});
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        s_ack = 1'b1;
        b.cmd = CMD_WRITE;
        b.tx_data = 8'($urandom);
        b.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b.cmd_valid = 1'b0;
        repeat (40 + $urandom_range(0, 60)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({b.sda_oe, b.scl_oe, b.busy, b.done, b.cmd_ready} !== 5'b0) begin
            errors++; $display("FAIL midrst_outputs: got %b want 00000", {b.sda_oe, b.scl_oe, b.busy, b.done, b.cmd_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({b.cmd_ready, b.ack_rx} !== 2'b10) begin
            errors++; $display("FAIL midrst_idle: got %b want 10", {b.cmd_ready, b.ack_rx});
        end
        exp_ack = 1'b0;
        run_cmd(CMD_STOP, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== LS || {sda_bus, scl_bus} !== 2'b11) begin
            errors++; $display("FAIL midrst_recover: got %0d bus %b want %0d 11", lat, {sda_bus, scl_bus}, LS);
        end
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        int lat;
        logic [7:0] d;
        run_cmd(CMD_START, 8'h00, 1'b0, lat);
        d = 8'($urandom);
        s_ack = 1'b1;
        st_arm = 1'b1;
        run_cmd(CMD_WRITE, d, 1'b0, lat);
        st_arm = 1'b0;
        checks++;
        if (lat !== LB + ST) begin errors++; $display("FAIL stretch_latency: got %0d want %0d", lat, LB + ST); end
        checks++;
        if (bus_byte() !== d || b.ack_rx !== 1'b1) begin
            errors++; $display("FAIL stretch_data: got %h ack %b want %h ack 1", bus_byte(), b.ack_rx, d);
        end
    endtask
`endif

    initial begin
        b.cmd_valid = 1'b0;
        b.cmd       = CMD_START;
        b.tx_data   = 8'h00;
        b.cmd_nack  = 1'b0;
        test_reset();
        test_start();
        test_write();
        test_read();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
